// File: rtl/instr_sequencer.sv
// rtl/instr_sequencer.sv - byte-loaded program store that issues 16-bit instructions and folds back results
module instr_sequencer #(
  parameter int DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ena,
  input  logic        wr_valid,
  input  logic [7:0]  wr_byte,
  output logic        wr_ready,
  input  logic        clr,
  input  logic        start,
  input  logic [7:0]  result_in,
  output logic [15:0] instr_out,
  output logic        instr_valid,
  output logic        busy,
  output logic        done,
  output logic [7:0]  last_result,
  output logic [7:0]  result_acc,
  output logic [3:0]  prog_count
);

  localparam int PCW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [3:0]       prog_count_q;
  logic [PCW-1:0]   pc_q;
  logic             half_q;
  logic [7:0]       hi_q;
  logic [7:0]       last_q;
  logic [7:0]       acc_q;
  logic [15:0]      mem_q [DEPTH];

  logic             wr_fire;
  logic             start_ok;
  logic             last_entry;

  always_comb begin
    wr_ready   = (state_q == S_IDLE) && (prog_count_q < 4'(DEPTH)) && !start && !clr;
    wr_fire    = ena && wr_valid && wr_ready;
    start_ok   = ena && (state_q == S_IDLE) && start && !clr &&
                 (prog_count_q != 4'd0) && !half_q;
    last_entry = (4'(pc_q) == (prog_count_q - 4'd1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (ena) begin
      case (state_q)
        S_IDLE:  if (start_ok) state_d = S_ISSUE;
        S_ISSUE: state_d = S_WAIT;
        S_WAIT:  state_d = last_entry ? S_DONE : S_ISSUE;
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    instr_out   = 16'h0000;
    instr_valid = 1'b0;
    busy        = (state_q != S_IDLE);
    done        = (state_q == S_DONE);
    if (state_q == S_ISSUE) begin
      instr_out   = mem_q[pc_q];
      instr_valid = 1'b1;
    end
  end

  // clr outranks start and writes; start_ok and wr_ready already exclude clr
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prog_count_q <= 4'd0;
      pc_q         <= '0;
      half_q       <= 1'b0;
      hi_q         <= 8'h00;
      last_q       <= 8'h00;
      acc_q        <= 8'h00;
    end else if (ena) begin
      case (state_q)
        S_IDLE: begin
          if (clr) begin
            prog_count_q <= 4'd0;
            half_q       <= 1'b0;
          end else if (start_ok) begin
            pc_q   <= '0;
            last_q <= 8'h00;
            acc_q  <= 8'h00;
          end else if (wr_fire) begin
            if (!half_q) begin
              hi_q   <= wr_byte;
              half_q <= 1'b1;
            end else begin
              prog_count_q <= prog_count_q + 4'd1;
              half_q       <= 1'b0;
            end
          end
        end
        S_WAIT: begin
          last_q <= result_in;
          acc_q  <= acc_q ^ result_in;
          if (!last_entry) pc_q <= pc_q + PCW'(1);
        end
        default: ;
      endcase
    end
  end

  // Program storage carries no reset; only entries below prog_count are ever read
  always_ff @(posedge clk) begin
    if (wr_fire && half_q) mem_q[prog_count_q[PCW-1:0]] <= {hi_q, wr_byte};
  end

  assign prog_count  = prog_count_q;
  assign last_result = last_q;
  assign result_acc  = acc_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// tb/tb_instr_sequencer.sv - scoreboard bench for instr_sequencer with a queue-based program model
module tb_instr_sequencer;
  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ena = 1'b1;
  logic        wr_valid = 1'b0;
  logic [7:0]  wr_byte = 8'h00;
  logic        clr = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  result_in = 8'h00;
  logic        wr_ready;
  logic [15:0] instr_out;
  logic        instr_valid, busy, done;
  logic [7:0]  last_result, result_acc;
  logic [3:0]  prog_count;

  instr_sequencer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .wr_valid(wr_valid), .wr_byte(wr_byte),
    .wr_ready(wr_ready), .clr(clr), .start(start), .result_in(result_in),
    .instr_out(instr_out), .instr_valid(instr_valid), .busy(busy), .done(done),
    .last_result(last_result), .result_acc(result_acc), .prog_count(prog_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [7:0] last;
    logic [7:0] acc;
    int         cyc;
  } done_t;

  logic [15:0] exp_instr[$];
  logic [7:0]  res_q[$];
  done_t       exp_done[$];
  logic [7:0]  fixed_q[$];

  logic [15:0] m_prog[$];
  bit          m_half = 1'b0;
  logic [7:0]  m_hi = 8'h00;
  int          stall_seen = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic miss(input string name);
    tests++;
    fails++;
    $display("FAIL %s: got event with empty scoreboard, expected none", name);
  endtask

  // Monitor: pops expected instructions and run results whenever the DUT presents them
  always @(negedge clk) begin
    if (rst_n) begin
      if (instr_valid) begin
        if (exp_instr.size() == 0) miss("unexpected_instr");
        else if (ena) begin
          chk("instr_out", instr_out, exp_instr.pop_front());
          result_in = (res_q.size() != 0) ? res_q.pop_front() : 8'h00;
        end else begin
          chk("instr_hold", instr_out, exp_instr[0]);
          stall_seen++;
        end
      end else begin
        chk("instr_nop", instr_out, 16'h0000);
      end
      if (done && ena) begin
        if (exp_done.size() == 0) miss("unexpected_done");
        else begin
          done_t d;
          d = exp_done.pop_front();
          chk("done_last_result", last_result, d.last);
          chk("done_result_acc", result_acc, d.acc);
          chk("done_cycle", cyc, d.cyc);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic flush();
    exp_instr.delete();
    res_q.delete();
    exp_done.delete();
  endtask

  // Leaves wr_valid high so consecutive calls hold the strobe
  task automatic put_byte(input logic [7:0] b);
    bit acc_ok;
    wr_valid = 1'b1;
    wr_byte  = b;
    acc_ok   = (m_prog.size() < DEPTH);
    @(negedge clk);
    chk("wr_ready", wr_ready, acc_ok);
    if (acc_ok) begin
      if (!m_half) begin
        m_hi   = b;
        m_half = 1'b1;
      end else begin
        m_prog.push_back({m_hi, b});
        m_half = 1'b0;
      end
    end
    tick();
  endtask

  task automatic arm(input int stall, input bit fixed);
    logic [7:0] acc, last, r;
    done_t d;
    acc = 8'h00;
    last = 8'h00;
    foreach (m_prog[i]) begin
      exp_instr.push_back(m_prog[i]);
      r = fixed ? fixed_q[i] : 8'($urandom);
      res_q.push_back(r);
      acc ^= r;
      last = r;
    end
    d.last = last;
    d.acc  = acc;
    d.cyc  = cyc + 2 * m_prog.size() + stall;
    exp_done.push_back(d);
  endtask

  task automatic run(input int stall, input bit fixed);
    bit ok;
    int t;
    ok = (m_prog.size() > 0) && !m_half;
    start = 1'b1;
    tick();
    start = 1'b0;
    if (ok) begin
      arm(stall, fixed);
      chk("busy_after_start", busy, 1);
      stall_seen = 0;
      if (stall > 0) begin
        ena = 1'b0;
        repeat (stall) tick();
        ena = 1'b1;
      end
      t = 0;
      while (exp_done.size() != 0 && t < 200) begin
        tick();
        t++;
      end
      if (exp_done.size() != 0) begin
        tests++;
        fails++;
        $display("FAIL run_timeout: got no done after %0d cycles, expected done", t);
        flush();
      end
      chk("stall_cycles", stall_seen, stall);
      tick();
      chk("busy_after_run", busy, 0);
    end else begin
      tick();
      chk("start_ignored_busy", busy, 0);
    end
  endtask

  task automatic load(input int nbytes);
    for (int i = 0; i < nbytes; i++) put_byte(8'($urandom));
    wr_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] prog35 [6];
    prog35 = '{8'h91, 8'h05, 8'h92, 8'h03, 8'hA0, 8'h12};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_instr_out", instr_out, 16'h0000);
    chk("rst_instr_valid", instr_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_prog_count", prog_count, 0);
    chk("rst_last_result", last_result, 0);
    chk("rst_result_acc", result_acc, 0);
    rst_n = 1'b1;
    tick();

    // Reference program with fixed results
    foreach (prog35[i]) put_byte(prog35[i]);
    wr_valid = 1'b0;
    chk("prog35_count", prog_count, 3);
    fixed_q = '{8'h05, 8'h03, 8'h08};
    run(0, 1'b1);
    chk("prog35_last", last_result, 8'h08);
    chk("prog35_acc", result_acc, 8'h0E);

    // Replay, then replay with a 3-cycle enable stall during ISSUE
    run(0, 1'b0);
    run(3, 1'b0);

    // Reset during WAIT of the second entry
    start = 1'b1;
    tick();
    start = 1'b0;
    arm(0, 1'b0);
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    chk("midrst_instr_valid", instr_valid, 0);
    chk("midrst_busy", busy, 0);
    tick();
    rst_n = 1'b1;
    flush();
    m_prog.delete();
    m_half = 1'b0;
    tick();
    chk("midrst_prog_count", prog_count, 0);
    chk("midrst_acc", result_acc, 0);
    run(0, 1'b0);

    // Half entry blocks start until completed
    put_byte(8'h91);
    wr_valid = 1'b0;
    run(0, 1'b0);
    put_byte(8'h05);
    wr_valid = 1'b0;
    run(0, 1'b0);

    // Capacity with wr_valid held high for 17 bytes
    clr = 1'b1;
    tick();
    clr = 1'b0;
    m_prog.delete();
    m_half = 1'b0;
    chk("clr_prog_count", prog_count, 0);
    for (int i = 0; i < 17; i++) begin
      put_byte(8'($urandom));
      if (i == 15) chk("cap_prog_count16", prog_count, 8);
    end
    wr_valid = 1'b0;
    chk("cap_prog_count17", prog_count, 8);
    run(0, 1'b0);

    // clr has priority over a simultaneous start
    clr = 1'b1;
    start = 1'b1;
    tick();
    clr = 1'b0;
    start = 1'b0;
    m_prog.delete();
    m_half = 1'b0;
    chk("clr_start_prog_count", prog_count, 0);
    tick();
    chk("clr_start_busy", busy, 0);

    // Randomised programs, stalls and occasional clears
    for (int k = 0; k < 10; k++) begin
      if ($urandom_range(0, 3) == 0) begin
        clr = 1'b1;
        tick();
        clr = 1'b0;
        m_prog.delete();
        m_half = 1'b0;
      end
      load($urandom_range(1, 7));
      run($urandom_range(0, 2), 1'b0);
      chk("rand_prog_count", prog_count, m_prog.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/instr_sequencer.md
INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 Parameter DEPTH, default 8: number of 16-bit program entries; legal values 2..8.
REQ-002 Port clk  input  1  single clock; all state changes on its rising edge.
REQ-003 Port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 Port ena  input  1  global enable; when low, every register holds its value.
REQ-005 Port wr_valid  input  1  program byte strobe.
REQ-006 Port wr_byte  input  8  program byte; high byte of each entry first, then low byte.
REQ-007 Port wr_ready  output  1  high when a program byte is accepted this cycle.
REQ-008 Port clr  input  1  discard the stored program (IDLE only).
REQ-009 Port start  input  1  begin executing the stored program.
REQ-010 Port result_in  input  8  result byte returned by the compute unit.
REQ-011 Port instr_out  output  16  instruction to the compute unit: {opcode[15:12], tgt[11:8], src0[7:4], src1[3:0]}.
REQ-012 Port instr_valid  output  1  instr_out holds a program entry this cycle.
REQ-013 Port busy  output  1  high in ISSUE, WAIT and DONE.
REQ-014 Port done  output  1  one-cycle pulse when the program completes.
REQ-015 Port last_result  output  8  last captured result_in.
REQ-016 Port result_acc  output  8  XOR of all results captured in the current run.
REQ-017 Port prog_count  output  4  number of complete entries stored.

Function
REQ-018 The FSM SHALL have the states IDLE, ISSUE, WAIT and DONE; all transitions occur only when ena=1.
REQ-019 In IDLE, wr_ready SHALL equal (prog_count<DEPTH) && !start && !clr; a byte is taken when wr_valid && wr_ready.
REQ-020 The first byte of an entry SHALL be latched as the high byte and set half_pending. The second byte SHALL write {high,low} to mem[prog_count], increment prog_count and clear half_pending.
REQ-021 In IDLE, clr SHALL set prog_count=0 and clear half_pending; clr has priority over start and over writes.
REQ-022 In IDLE, start SHALL be accepted only when prog_count>0 and half_pending=0; otherwise it is ignored with no state change.
REQ-023 Accepting start SHALL set pc=0, last_result=0 and result_acc=0, and move to ISSUE on the next edge.
REQ-024 In ISSUE: instr_out=mem[pc] and instr_valid=1 for exactly one cycle; next state is WAIT.
REQ-025 In WAIT: at the end of the cycle, result_in SHALL be captured as last_result <= result_in and result_acc <= result_acc ^ result_in.
REQ-026 In WAIT: if pc==prog_count-1 the next state is DONE; otherwise pc increments and the next state is ISSUE.
REQ-027 Each entry SHALL therefore take 2 cycles, and DONE is entered 2*prog_count cycles after the start-accept edge.
REQ-028 DONE SHALL last one cycle with done=1, then return to IDLE; the program and prog_count are retained so a new start replays it.
REQ-029 Outside ISSUE, instr_out SHALL be 16'h0000 (No-Op) and instr_valid=0.
REQ-030 In ISSUE, WAIT and DONE, wr_valid, clr and start SHALL be ignored, and wr_ready=0.
REQ-031 When ena=0, all outputs SHALL hold their values, including an in-progress ISSUE cycle.
REQ-032 mem SHALL be an unreset register array; reading entries at index >= prog_count is never performed.

Reset
REQ-033 While rst_n=0, regardless of clk, the block SHALL hold: state=IDLE, prog_count=0, pc=0, half_pending=0, last_result=0, result_acc=0, instr_out=0, instr_valid=0, busy=0, done=0.
REQ-034 Reset asserted mid-run SHALL abort the run immediately; the first edge after release sees IDLE with the program discarded.

Verification
REQ-035 Load sequence: bytes 91,05,92,03,A0,12, then start. Required: instr_out = 9105, 0000, 9203, 0000, A012 on consecutive cycles. With the model driving result_in = 05, 03, 08 in the WAIT cycles: last_result=08, result_acc=0E, done pulse on the 7th cycle after start accept.
REQ-036 Capacity: 17 bytes with wr_valid held high. Required: prog_count=8 and wr_ready=0 after the 16th byte, and the 17th byte is dropped.
REQ-037 Single byte 91, then start. Required: start ignored, busy=0. Then byte 05 and start. Required: run executes 9105.
REQ-038 Rerun: after REQ-035 completes, start again. Required: identical instruction sequence, result_acc restarts from 00.
REQ-039 Assert rst_n=0 during WAIT of the second entry. Required: immediate instr_valid=0 and busy=0, and prog_count=0 after release.
REQ-040 Hold ena=0 for 3 cycles during ISSUE. Required: instr_out and instr_valid held for 3 cycles, and the run finishes 3 cycles late.
